// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between program memory and decode.
// Fetches FETCH_BYTES bytes at a time into a circular byte queue. Presents one
// aligned 8080 instruction (1..3 bytes) per handshake as {opcode, byte1, byte2}.
// A branch redirect flushes the queue. A fetch that is still in flight at the
// redirect is discarded when its response arrives.
// Optional build macro IFQ_BYPASS_EN: the head instruction is assembled from the
// queue bytes followed by the arriving fetch_data (0-cycle fill latency).
module ifetch_queue #(
  parameter int                FETCH_BYTES = 2,
  parameter int                DEPTH       = 8,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      fetch_req,
  output logic [ADDR_W-1:0]         fetch_addr,
  input  logic                      fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]  fetch_data,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [23:0]               instr,
  output logic [1:0]                instr_len,
  output logic [ADDR_W-1:0]         instr_pc,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]  FB_OCC    = OCC_W'(FETCH_BYTES);
  localparam logic [OCC_W-1:0]  SPACE_LIM = OCC_W'(DEPTH - FETCH_BYTES);
  localparam logic [PTR_W-1:0]  FB_PTR    = PTR_W'(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] FB_ADDR   = ADDR_W'(FETCH_BYTES);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // no fetch outstanding
    ST_WAIT = 2'd1,  // fetch outstanding, response will be stored
    ST_DROP = 2'd2   // stale fetch outstanding, response will be discarded
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        queue_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [OCC_W-1:0]  occ_r, occ_s;
  logic [ADDR_W-1:0] head_pc_r, fetch_addr_r;

  logic              space_s, bypass_s, push_s, pop_s, valid_core_s;
  logic [OCC_W-1:0]  avail_s;
  logic [7:0]        view_s [3];
  logic [1:0]        len_s;

  // Instruction length from the 8080 opcode byte.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) begin
      len = 2'd3;                                   // LXI
    end else if (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) begin
      len = 2'd3;                                   // Jccc / Cccc
    end else if (op == 8'h22 || op == 8'h2A || op == 8'h32 || op == 8'h3A ||
                 op == 8'hC3 || op == 8'hCB || op == 8'hCD || op == 8'hDD ||
                 op == 8'hED || op == 8'hFD) begin
      len = 2'd3;                                   // direct address / jumps / calls
    end else if (op[2:0] == 3'b110 && (op[7:6] == 2'b00 || op[7:6] == 2'b11)) begin
      len = 2'd2;                                   // MVI, ADI..CPI
    end else if (op == 8'hD3 || op == 8'hDB) begin
      len = 2'd2;                                   // OUT / IN
    end else begin
      len = 2'd1;
    end
    return len;
  endfunction

`ifdef IFQ_BYPASS_EN
  assign bypass_s = (state_r == ST_WAIT) && fetch_valid;
`else
  assign bypass_s = 1'b0;
`endif

  // Only the registered occupancy grants fetch space; same-cycle pops are not credited.
  assign space_s = (occ_r <= SPACE_LIM);
  assign push_s  = (state_r == ST_WAIT) && fetch_valid && !redirect;
  assign avail_s = occ_r + (bypass_s ? FB_OCC : {OCC_W{1'b0}});

  // Head view: the first three bytes, with queued bytes first and then bypassed lanes.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      view_s[k] = 8'h00;
      if (OCC_W'(k) < occ_r) begin
        view_s[k] = queue_r[rd_ptr_r + PTR_W'(k)];
      end else begin
        for (int j = 0; j < FETCH_BYTES; j++) begin
          view_s[k] = (bypass_s && ((occ_r + OCC_W'(j)) == OCC_W'(k))) ?
                      fetch_data[8*j +: 8] : view_s[k];
        end
      end
    end
  end

  assign len_s        = op_len(view_s[0]);
  assign valid_core_s = (avail_s >= OCC_W'(len_s)) && !redirect;
  assign pop_s        = valid_core_s && instr_ready;

  assign instr_valid = valid_core_s && !rst;
  assign instr_len   = len_s;
  assign instr_pc    = head_pc_r;
  assign fetch_addr  = fetch_addr_r;
  assign occupancy   = occ_r;
  assign fetch_req   = (state_r == ST_RUN) && space_s && !redirect && !rst;

  // Decode-layout instruction word; bytes beyond the length are 0.
  always_comb begin
    instr = 24'h000000;
    if (instr_valid) begin
      instr[23:16] = view_s[0];
      instr[15:8]  = (len_s >= 2'd2) ? view_s[1] : 8'h00;
      instr[7:0]   = (len_s == 2'd3) ? view_s[2] : 8'h00;
    end else begin
      instr = 24'h000000;
    end
  end

  // Fetch sequencing; redirect overrides everything in its cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redirect)     state_s = ST_RUN;
        else if (space_s) state_s = ST_WAIT;
        else              state_s = ST_RUN;
      end
      ST_WAIT, ST_DROP: begin
        if (redirect)         state_s = fetch_valid ? ST_RUN : ST_DROP;
        else if (fetch_valid) state_s = ST_RUN;
        else                  state_s = state_r;
      end
      default: state_s = ST_RUN;
    endcase
  end

  // Next occupancy from the push and pop in this cycle.
  always_comb begin
    occ_s = occ_r;
    if (push_s) occ_s = occ_s + FB_OCC;
    else        occ_s = occ_s;
    if (pop_s)  occ_s = occ_s - OCC_W'(len_s);
    else        occ_s = occ_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_RUN;
    else     state_r <= state_s;
  end

  // Pointers, occupancy and program counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      occ_r        <= '0;
      head_pc_r    <= RESET_PC;
      fetch_addr_r <= RESET_PC;
    end else if (redirect) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      occ_r        <= '0;
      head_pc_r    <= redirect_pc;
      fetch_addr_r <= redirect_pc;
    end else begin
      occ_r <= occ_s;
      if (push_s) begin
        wr_ptr_r     <= wr_ptr_r + FB_PTR;
        fetch_addr_r <= fetch_addr_r + FB_ADDR;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(len_s);
        head_pc_r <= head_pc_r + ADDR_W'(len_s);
      end
    end
  end

  // Byte storage; full check upstream guarantees no live byte is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) queue_r[i] <= 8'h00;
    end else if (push_s) begin
      for (int j = 0; j < FETCH_BYTES; j++) queue_r[wr_ptr_r + PTR_W'(j)] <= fetch_data[8*j +: 8];
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int FB = 2;
  localparam int DEPTH = 8;
  localparam int AW = 16;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, fetch_req, fetch_valid, redirect, instr_valid, instr_ready;
  logic [AW-1:0] fetch_addr, redirect_pc, instr_pc;
  logic [8*FB-1:0] fetch_data;
  logic [23:0] instr;
  logic [1:0] instr_len;
  logic [3:0] occupancy;

  int checks = 0;
  int errors = 0;
  logic [7:0] prog [0:65535];
  int lat = 1;
  int cnt;
  int fetch_cnt;
  logic [15:0] paddr;

  always #5 clk = ~clk;

  ifetch_queue #(.FETCH_BYTES(FB), .DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_len(instr_len), .instr_pc(instr_pc), .occupancy(occupancy)
  );

  // Memory model: samples fetch_req mid-cycle, answers 'lat' cycles later.
  initial begin
    fetch_valid = 1'b0; fetch_data = '0; cnt = 0; fetch_cnt = 0; paddr = 16'h0000;
    forever begin
      @(negedge clk);
      fetch_valid = 1'b0;
      if (rst) begin
        cnt = 0; fetch_cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            fetch_valid = 1'b1;
            for (int j = 0; j < FB; j++) fetch_data[8*j +: 8] = prog[paddr + 16'(j)];
          end
        end
        if (fetch_req) begin
          paddr = fetch_addr; cnt = lat; fetch_cnt++;
        end
      end
    end
  end

  task automatic cyc_drive;  @(posedge clk); #1; endtask
  task automatic cyc_sample; @(negedge clk); #1; endtask

  task automatic clear_prog;
    for (int a = 0; a < 65536; a++) prog[a] = 8'h00;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0; lat = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_instr(output bit ok);
    int n;
    ok = 1'b0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); #1;
      n++;
      ok = instr_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc_sample;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 24'h000000) begin errors++; $display("FAIL rst_instr got %h want 000000", instr); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", fetch_req); end
    checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL rst_faddr got %h want 0000", fetch_addr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", instr_pc); end
    do_reset;
    cyc_sample;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", fetch_req); end
    checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL first_faddr got %h want 0000", fetch_addr); end
  endtask

  task automatic test_sequence;
    logic [23:0] exp_i [3];
    logic [1:0]  exp_l [3];
    logic [15:0] exp_p [3];
    bit ok;
    exp_i = '{24'h3E4200, 24'h000000, 24'hC33412};
    exp_l = '{2'd2, 2'd1, 2'd3};
    exp_p = '{16'h0000, 16'h0002, 16'h0003};
    clear_prog;
    prog[0] = 8'h3E; prog[1] = 8'h42; prog[2] = 8'h00;
    prog[3] = 8'hC3; prog[4] = 8'h34; prog[5] = 8'h12;
    do_reset;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_instr(ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_timeout idx %0d got no instr_valid want instr_valid", k); end
      checks++; if (instr !== exp_i[k]) begin errors++; $display("FAIL seq_instr idx %0d got %h want %h", k, instr, exp_i[k]); end
      checks++; if (instr_len !== exp_l[k]) begin errors++; $display("FAIL seq_len idx %0d got %0d want %0d", k, instr_len, exp_l[k]); end
      checks++; if (instr_pc !== exp_p[k]) begin errors++; $display("FAIL seq_pc idx %0d got %h want %h", k, instr_pc, exp_p[k]); end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    clear_prog;
    do_reset;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (fetch_cnt !== 4) begin errors++; $display("FAIL bp_fetches got %0d want 4", fetch_cnt); end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL bp_occ got %0d want 8", occupancy); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b want 0", fetch_req); end
    cyc_drive;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_instr(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout idx %0d got no instr_valid want instr_valid", i); end
      checks++; if (instr_pc !== 16'(i)) begin errors++; $display("FAIL bp_pc got %h want %h", instr_pc, 16'(i)); end
      checks++; if (instr_len !== 2'd1) begin errors++; $display("FAIL bp_len got %0d want 1", instr_len); end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    bit ok;
    clear_prog;
    prog[16'h0000] = 8'hAA; prog[16'h0001] = 8'hBB;
    prog[16'h0100] = 8'h3E; prog[16'h0101] = 8'h55;
    do_reset;
    lat = 3;                                         // stale reply lands two cycles after redirect
    cyc_sample;                                      // cycle 0: fetch of 0000 issued
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL rw_req0 got %b want 1", fetch_req); end
    cyc_drive;                                       // cycle 1: redirect while WAIT
    redirect = 1'b1; redirect_pc = 16'h0100; lat = 1;
    cyc_sample;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_redir got %b want 0", instr_valid); end
    cyc_drive;                                       // cycle 2: DROP
    redirect = 1'b0;
    cyc_sample;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rw_req_drop got %b want 0", fetch_req); end
    cyc_drive;                                       // cycle 3: stale reply arrives
    cyc_sample;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rw_req_stale got %b want 0", fetch_req); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rw_occ_stale got %0d want 0", occupancy); end
    cyc_drive;                                       // cycle 4: refetch from 0100
    cyc_sample;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rw_occ_after got %0d want 0", occupancy); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL rw_req_new got %b want 1", fetch_req); end
    checks++; if (fetch_addr !== 16'h0100) begin errors++; $display("FAIL rw_faddr got %h want 0100", fetch_addr); end
    wait_instr(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rw_timeout got no instr_valid want instr_valid"); end
    checks++; if (instr !== 24'h3E5500) begin errors++; $display("FAIL rw_instr got %h want 3E5500", instr); end
    checks++; if (instr_pc !== 16'h0100) begin errors++; $display("FAIL rw_pc got %h want 0100", instr_pc); end
  endtask

  task automatic test_redirect_same;
    bit ok;
    clear_prog;
    prog[16'h0000] = 8'h3E; prog[16'h0001] = 8'h77;
    do_reset;                                        // cycle 0: fetch of 0000
    cyc_drive;                                       // cycle 1: reply and redirect together
    redirect = 1'b1; redirect_pc = 16'h0200;
    cyc_sample;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b want 0", instr_valid); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rs_req_redir got %b want 0", fetch_req); end
    cyc_drive;
    redirect = 1'b0;
    cyc_sample;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rs_occ got %0d want 0", occupancy); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL rs_req got %b want 1", fetch_req); end
    checks++; if (fetch_addr !== 16'h0200) begin errors++; $display("FAIL rs_faddr got %h want 0200", fetch_addr); end
    wait_instr(ok);
    checks++; if (instr_pc !== 16'h0200) begin errors++; $display("FAIL rs_pc got %h want 0200", instr_pc); end
  endtask

  task automatic test_wrap;
    bit ok;
    clear_prog;
    prog[16'hFFFE] = 8'h01; prog[16'hFFFF] = 8'h34;
    prog[16'h0000] = 8'h12; prog[16'h0001] = 8'h00;
    do_reset;
    redirect = 1'b1; redirect_pc = 16'hFFFE; instr_ready = 1'b1;
    cyc_drive;
    redirect = 1'b0;
    wait_instr(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got no instr_valid want instr_valid"); end
    checks++; if (instr !== 24'h013412) begin errors++; $display("FAIL wrap_instr got %h want 013412", instr); end
    checks++; if (instr_len !== 2'd3) begin errors++; $display("FAIL wrap_len got %0d want 3", instr_len); end
    checks++; if (instr_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc got %h want FFFE", instr_pc); end
    cyc_sample;
    checks++; if (fetch_addr !== 16'h0002) begin errors++; $display("FAIL wrap_faddr got %h want 0002", fetch_addr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_next_valid got %b want 1", instr_valid); end
    checks++; if (instr_pc !== 16'h0001) begin errors++; $display("FAIL wrap_next_pc got %h want 0001", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_bypass;
    clear_prog;
    do_reset;
    cyc_sample;                                      // cycle 0: queue empty, fetch issued
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL byp_c0_valid got %b want 0", instr_valid); end
    cyc_drive;
    cyc_sample;                                      // cycle 1: reply 00 00 arrives
    checks++; if (instr_valid !== BYP) begin errors++; $display("FAIL byp_c1_valid got %b want %b", instr_valid, BYP); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL byp_c1_pc got %h want 0000", instr_pc); end
    cyc_drive;
    cyc_sample;                                      // cycle 2: bytes now queued
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL byp_c2_valid got %b want 1", instr_valid); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL byp_c2_occ got %0d want 2", occupancy); end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
    test_reset;
    test_sequence;
    test_backpressure;
    test_redirect_wait;
    test_redirect_same;
    test_wrap;
    test_bypass;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
